// File: rtl/data_mem_responder.sv
// Single-port word memory behind a fixed-latency request/response handshake.
// A three-state FSM paces each accepted read or write and pulses mem_ready on completion.
module data_mem_responder #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              memory_r_en,
    input  logic              memory_w_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_in,
    output logic [DATA_W-1:0] mem_out,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state, next_state;
    logic [3:0]        cnt, cnt_next;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              accept, enter_resp, err_set;
    logic              commit_write;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;

    assign mem_busy = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (memory_r_en ^ memory_w_en) begin
                    accept   = 1'b1;
                    cnt_next = LAT_M1;
                    if (LAT_M1 == 4'd0) begin
                        next_state = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    next_state = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With LATENCY=1 the request goes straight to RESP, so the live inputs are committed.
    assign commit_write = (state == IDLE) ? memory_w_en : op_write;
    assign commit_addr  = (state == IDLE) ? addr        : addr_q;
    assign commit_data  = (state == IDLE) ? mem_in      : data_q;

    assign err_set = (mem_busy && (memory_r_en || memory_w_en)) ||
                     ((state == IDLE) && memory_r_en && memory_w_en);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_write  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            mem_out   <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            mem_ready <= (state == RESP);
            if (err_set) begin
                mem_err <= 1'b1;
            end
            if (accept) begin
                op_write <= memory_w_en;
                addr_q   <= addr;
                data_q   <= mem_in;
            end
            if (enter_resp && !commit_write) begin
                mem_out <= mem[commit_addr];
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; the async reset still aborts a
    // pending write because the FSM is held in IDLE, which suppresses enter_resp.
    always_ff @(posedge clk) begin
        if (enter_resp && commit_write) begin
            mem[commit_addr] <= commit_data;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance driven from a vector
// table plus corner-case sequences, and a LATENCY=1 instance for held back-to-back reads.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       init_n;
    logic       r_en, w_en, r1_en, w1_en;
    logic [7:0] addr, mem_in, addr1, mem_in1;
    logic [7:0] mem_out, mem_out1;
    logic       mem_ready, mem_busy, mem_err;
    logic       mem_ready1, mem_busy1, mem_err1;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_out;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(2), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .init_n(init_n), .memory_r_en(r_en), .memory_w_en(w_en),
        .addr(addr), .mem_in(mem_in), .mem_out(mem_out),
        .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    data_mem_responder #(.LATENCY(1), .ADDR_W(8), .DATA_W(8)) dut1 (
        .clk(clk), .init_n(init_n), .memory_r_en(r1_en), .memory_w_en(w1_en),
        .addr(addr1), .mem_in(mem_in1), .mem_out(mem_out1),
        .mem_ready(mem_ready1), .mem_busy(mem_busy1), .mem_err(mem_err1)
    );

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge; runs one LATENCY=2 transaction and leaves at a negedge.
    task automatic transact(input logic we, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] exp_out);
        w_en = we; r_en = !we; addr = a; mem_in = d;
        @(posedge clk);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
        check("busy_k",    mem_busy,  1'b1);
        check("ready_k",   mem_ready, 1'b0);
        @(negedge clk);
        check("busy_k1",   mem_busy,  1'b1);
        check("ready_k1",  mem_ready, 1'b0);
        if (!we) last_out = exp_out;
        @(negedge clk);
        check("busy_k2",   mem_busy,  1'b0);
        check("ready_k2",  mem_ready, 1'b1);
        check("out_k2",    mem_out,   last_out);
        @(negedge clk);
        check("ready_k3",  mem_ready, 1'b0);
        check("out_hold",  mem_out,   last_out);
    endtask

    task automatic reset_pulse();
        init_n = 1'b0;
        #1;
        check("rst_out",   mem_out,   8'h00);
        check("rst_ready", mem_ready, 1'b0);
        check("rst_busy",  mem_busy,  1'b0);
        check("rst_err",   mem_err,   1'b0);
        last_out = 8'h00;
        @(negedge clk);
        init_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 8'h20, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 8'h21, 8'hC3, 8'h00};
        vecs[4] = '{1'b0, 8'h20, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 8'h21, 8'h00, 8'hC3};
        vecs[6] = '{1'b1, 8'hFF, 8'h12, 8'h00};
        vecs[7] = '{1'b1, 8'h10, 8'h77, 8'h00};
        vecs[8] = '{1'b0, 8'h10, 8'h00, 8'h77};
        vecs[9] = '{1'b0, 8'hFF, 8'h00, 8'h12};

        init_n = 1'b0;
        r_en = 1'b0; w_en = 1'b0; addr = 8'h00; mem_in = 8'h00;
        r1_en = 1'b0; w1_en = 1'b0; addr1 = 8'h00; mem_in1 = 8'h00;
        last_out = 8'h00;
        #2;
        check("init_out",   mem_out,   8'h00);
        check("init_ready", mem_ready, 1'b0);
        check("init_busy",  mem_busy,  1'b0);
        check("init_err",   mem_err,   1'b0);
        @(negedge clk);
        init_n = 1'b1;

        // First transaction starts on the first rising edge with init_n high.
        foreach (vecs[i]) begin
            transact(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp_out);
        end
        check("table_err", mem_err, 1'b0);

        // Read strobe during WAIT of a write: ignored, flags error, write still completes.
        w_en = 1'b1; addr = 8'h20; mem_in = 8'h99;
        @(posedge clk);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b1; addr = 8'h10;
        @(posedge clk);
        @(negedge clk);
        r_en = 1'b0;
        check("ign_err",   mem_err,   1'b1);
        check("ign_busy",  mem_busy,  1'b1);
        check("ign_ready", mem_ready, 1'b0);
        @(negedge clk);
        check("ign_done",  mem_ready, 1'b1);
        check("ign_out",   mem_out,   last_out);
        @(negedge clk);
        transact(1'b0, 8'h20, 8'h00, 8'h99);
        check("err_sticky", mem_err, 1'b1);
        reset_pulse();

        // Both strobes in IDLE: nothing accepted, error raised.
        r_en = 1'b1; w_en = 1'b1; addr = 8'h30; mem_in = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        r_en = 1'b0; w_en = 1'b0;
        check("both_busy",  mem_busy,  1'b0);
        check("both_ready", mem_ready, 1'b0);
        check("both_err",   mem_err,   1'b1);
        @(negedge clk);
        check("both_ready2", mem_ready, 1'b0);
        check("both_err2",   mem_err,   1'b1);
        reset_pulse();

        // Reset during WAIT aborts the write to 0xFF; the old word survives.
        transact(1'b0, 8'h10, 8'h00, 8'h77);
        w_en = 1'b1; addr = 8'hFF; mem_in = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        w_en = 1'b0;
        check("abort_busy", mem_busy, 1'b1);
        reset_pulse();
        transact(1'b0, 8'hFF, 8'h00, 8'h12);

        // LATENCY=1 instance: write, then a held read strobe accepted back to back.
        w1_en = 1'b1; addr1 = 8'h05; mem_in1 = 8'h66;
        @(posedge clk);
        @(negedge clk);
        w1_en = 1'b0;
        check("l1_w_busy",  mem_busy1,  1'b1);
        check("l1_w_ready", mem_ready1, 1'b0);
        @(negedge clk);
        check("l1_w_done",  mem_ready1, 1'b1);
        check("l1_w_idle",  mem_busy1,  1'b0);
        r1_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("l1_r_busy",  mem_busy1,  1'b1);
        check("l1_r_ready", mem_ready1, 1'b0);
        @(negedge clk);
        check("l1_r_done",  mem_ready1, 1'b1);
        check("l1_r_out",   mem_out1,   8'h66);
        check("l1_r_idle",  mem_busy1,  1'b0);
        @(negedge clk);
        r1_en = 1'b0;
        check("l1_reacc_busy",  mem_busy1,  1'b1);
        check("l1_reacc_ready", mem_ready1, 1'b0);
        @(negedge clk);
        check("l1_reacc_done",  mem_ready1, 1'b1);
        check("l1_reacc_out",   mem_out1,   8'h66);
        @(negedge clk);
        check("l1_quiet",       mem_ready1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001: Parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-002: Parameter ADDR_W, default 8, address width; storage depth is 2**ADDR_W words.
REQ-003: Parameter DATA_W, default 8, data word width.
REQ-004: clk  input  1  single clock; all state changes on its rising edge.
REQ-005: init_n  input  1  reset, asynchronous, active-low.
REQ-006: memory_r_en  input  1  read request strobe from the control sequencer.
REQ-007: memory_w_en  input  1  write request strobe from the control sequencer.
REQ-008: addr  input  ADDR_W  request address.
REQ-009: mem_in  input  DATA_W  write data.
REQ-010: mem_out  output  DATA_W  read data; holds the last completed read value.
REQ-011: mem_ready  output  1  one-cycle completion pulse for an accepted read or write.
REQ-012: mem_busy  output  1  high while a request is in flight.
REQ-013: mem_err  output  1  sticky protocol-violation flag.

Function
REQ-014: The FSM SHALL have states IDLE, WAIT and RESP; mem_busy SHALL be high in WAIT and RESP only.
REQ-015: In IDLE, a rising edge with exactly one of memory_r_en/memory_w_en high SHALL accept the request, latching op, addr and mem_in.
REQ-016: On acceptance, a down-counter SHALL load LATENCY-1; the FSM SHALL go to RESP if the loaded value is 0, else to WAIT.
REQ-017: In WAIT, the counter SHALL decrement each edge; the edge where it reaches 0 SHALL move the FSM to RESP.
REQ-018: Net latency: a request accepted at edge k SHALL produce mem_ready high for exactly the cycle after edge k+LATENCY.
REQ-019: A write SHALL commit latched data to latched address at the edge entering RESP.
REQ-020: A read SHALL load mem_out from the latched address at the edge entering RESP; mem_out SHALL hold until the next read completes.
REQ-021: From RESP, the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-022: Requests arriving while mem_busy is high SHALL be ignored (no storage or mem_out change) and SHALL set mem_err.
REQ-023: Both strobes high in IDLE SHALL accept no request, leave the FSM in IDLE and set mem_err.
REQ-024: A read to an address written by the immediately preceding completed write SHALL return the new data.
REQ-025: Strobes are level-sampled; a strobe held high through RESP into IDLE SHALL be accepted as a new request at the first IDLE edge.
REQ-026: mem_err SHALL clear only on reset.
REQ-027: Addresses SHALL not wrap or be checked; every ADDR_W value is a legal distinct word.

Reset
REQ-028: init_n low SHALL immediately force FSM to IDLE, counter to 0, mem_out to 0, mem_ready 0, mem_busy 0, mem_err 0.
REQ-029: Reset during WAIT or RESP SHALL abort the request; a write not yet committed SHALL not be committed.
REQ-030: Storage contents SHALL not be reset; a read of a never-written word returns an unspecified value.
REQ-031: The first request SHALL be accepted on the first rising edge with init_n high.

Verification (LATENCY=2, ADDR_W=8, DATA_W=8)
REQ-032: Write 0xA5 to 0x10 at edge k -> mem_busy high from k, mem_ready high only for cycle after k+2, mem_err 0.
REQ-033: Then read 0x10 -> mem_out = 0xA5 with mem_ready one cycle; mem_out stays 0xA5 after mem_ready drops.
REQ-034: Read strobe asserted during WAIT of a write to 0x20 -> ignored, mem_err = 1; write of 0x20 completes normally.
REQ-035: Both strobes high in IDLE -> no mem_ready, mem_busy stays 0, mem_err = 1 until init_n pulse.
REQ-036: Write 0x3C to 0xFF, drop init_n during WAIT -> outputs zeroed at once; later read of 0xFF does not return 0x3C unless previously written.
REQ-037: LATENCY=1 build: read at edge k -> mem_ready in cycle after k+1; back-to-back held read strobe re-accepted at first IDLE edge.
